// File: rtl/dmem_arb_pkg.sv
// dmem_bus_arbiter shared types and constants.
// Watchdog build option: DMEM_ARB_WATCHDOG_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam int DEF_TIMEOUT = 15;
  localparam int unsigned TIMEOUT_RDATA = 0;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Two-master request side plus shared slave bus of the dmem arbiter.
// Watchdog build option: DMEM_ARB_WATCHDOG_EN.
interface dmem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          m0_req;
  logic          m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic          s_rd;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ready;

  logic          busy;
  logic          err;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  s_rdata, s_ready,
    output m0_rdata, m0_ack,
    output m1_rdata, m1_ack,
    output s_rd, s_wr, s_addr, s_wdata,
    output busy, err
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output s_rdata, s_ready,
    input  m0_rdata, m0_ack,
    input  m1_rdata, m1_ack,
    input  s_rd, s_wr, s_addr, s_wdata,
    input  busy, err
  );

endinterface

// File: rtl/dmem_arb_watchdog.sv
// BUSY-cycle counter that aborts a stalled slave access.
// Only instantiated when DMEM_ARB_WATCHDOG_EN is defined.
module dmem_arb_watchdog
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (run && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the BUSY cycle whose closing edge brings the count to TIMEOUT.
  assign expire = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter of CPU (m0) and DMA (m1) onto the dmem/peripheral bus.
// Optional stall watchdog: define DMEM_ARB_WATCHDOG_EN.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             sysclk,
  input  logic             reset,
  dmem_bus_arbiter_if.slave bus
);

  state_t state;
  owner_t owner;
  owner_t last;

  logic          any_req;
  logic          pick_m1;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          wd_expire;
  logic          done_ev;
  logic          tmo;

  assign any_req = bus.m0_req | bus.m1_req;

  // m1 wins alone, or on a tie when m0 was served last.
  assign pick_m1 = bus.m1_req &
                   (~bus.m0_req | (last == M0));

  assign sel_wr    = pick_m1 ? bus.m1_wr    : bus.m0_wr;
  assign sel_addr  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = pick_m1 ? bus.m1_wdata : bus.m0_wdata;

`ifdef DMEM_ARB_WATCHDOG_EN
  dmem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .sysclk (sysclk),
    .reset  (reset),
    .start  ((state == IDLE) & any_req),
    .run    (state == BUSY),
    .expire (wd_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign wd_expire = 1'b0;
`endif

  assign done_ev = (state == BUSY) &
                   (bus.s_ready | wd_expire);
  assign tmo     = wd_expire & ~bus.s_ready;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= M0;
      last         <= M1;
      bus.s_rd     <= 1'b0;
      bus.s_wr     <= 1'b0;
      bus.s_addr   <= '0;
      bus.s_wdata  <= '0;
      bus.m0_rdata <= '0;
      bus.m1_rdata <= '0;
      bus.m0_ack   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state       <= BUSY;
            owner       <= pick_m1 ? M1 : M0;
            bus.s_rd    <= ~sel_wr;
            bus.s_wr    <= sel_wr;
            bus.s_addr  <= sel_addr;
            bus.s_wdata <= sel_wdata;
            bus.busy    <= 1'b1;
          end
        end
        BUSY: begin
          if (done_ev) begin
            state    <= DONE;
            last     <= owner;
            bus.s_rd <= 1'b0;
            bus.s_wr <= 1'b0;
            bus.err  <= tmo;
            if (owner == M1) begin
              bus.m1_ack <= 1'b1;
              if (tmo)
                bus.m1_rdata <= DW'(TIMEOUT_RDATA);
              else if (!bus.s_wr)
                bus.m1_rdata <= bus.s_rdata;
            end else begin
              bus.m0_ack <= 1'b1;
              if (tmo)
                bus.m0_rdata <= DW'(TIMEOUT_RDATA);
              else if (!bus.s_wr)
                bus.m0_rdata <= bus.s_rdata;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
          bus.err    <= 1'b0;
          bus.busy   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter (directed vectors).
// Build with DMEM_ARB_WATCHDOG_EN to exercise the watchdog path.
module tb_dmem_bus_arbiter;
  import dmem_arb_pkg::*;

`ifdef DMEM_ARB_WATCHDOG_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  always #5 sysclk = ~sysclk;

  dmem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_bus_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  ack_t ack_q[$];
  cmd_t cmd_q[$];
  int   rise_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          slave_delay = 0;
  logic [31:0] rd_base = '0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic wr,
                          input logic [31:0] a,
                          input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d;
    cmd_q.push_back(c);
  endtask

  task automatic push_ack(input logic o,
                          input logic [31:0] r,
                          input logic e);
    ack_t k;
    k.owner = o; k.rdata = r; k.err = e;
    ack_q.push_back(k);
  endtask

  // Slave model: ready after slave_delay strobe cycles.
  initial begin
    int scnt;
    scnt = 0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    forever begin
      @(negedge sysclk);
      if (!reset) begin
        bus.s_ready = 1'($urandom);
        bus.s_rdata = $urandom;
        scnt = 0;
      end else if (bus.s_rd | bus.s_wr) begin
        if (scnt == slave_delay) begin
          bus.s_ready = 1'b1;
          bus.s_rdata = rd_base ^ bus.s_addr;
        end else begin
          bus.s_ready = 1'b0;
        end
        scnt++;
      end else begin
        bus.s_ready = 1'b0;
        scnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and strobe rise.
  initial begin
    logic prev_ack, prev_st, st;
    ack_t e;
    cmd_t c;
    prev_ack = 1'b0;
    prev_st  = 1'b0;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        if (bus.m0_ack || bus.m1_ack) begin
          chk("ack_excl", 32'(bus.m0_ack & bus.m1_ack), 0);
          chk("ack_width", 32'(prev_ack), 0);
          if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected m0=%b m1=%b want=none",
                     bus.m0_ack, bus.m1_ack);
          end else begin
            e = ack_q.pop_front();
            chk("ack_owner", 32'(bus.m1_ack), 32'(e.owner));
            chk("ack_rdata",
                e.owner ? bus.m1_rdata : bus.m0_rdata, e.rdata);
            chk("ack_err", 32'(bus.err), 32'(e.err));
          end
        end
        st = bus.s_rd | bus.s_wr;
        if (st && !prev_st) begin
          rise_cyc.push_back(cyc);
          chk("strobe_excl", 32'(bus.s_rd & bus.s_wr), 0);
          if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected addr=%h want=none",
                     bus.s_addr);
          end else begin
            c = cmd_q.pop_front();
            chk("cmd_wr", 32'(bus.s_wr), 32'(c.wr));
            chk("cmd_addr", bus.s_addr, c.addr);
            chk("cmd_wdata", bus.s_wdata, c.wdata);
          end
        end
        prev_ack = bus.m0_ack | bus.m1_ack;
        prev_st  = st;
      end else begin
        prev_ack = 1'b0;
        prev_st  = 1'b0;
      end
    end
  end

  task automatic set_master(input logic m, input logic req,
                            input logic wr,
                            input logic [31:0] a,
                            input logic [31:0] d);
    if (m) begin
      bus.m1_req = req; bus.m1_wr = wr;
      bus.m1_addr = a; bus.m1_wdata = d;
    end else begin
      bus.m0_req = req; bus.m0_wr = wr;
      bus.m0_addr = a; bus.m0_wdata = d;
    end
  endtask

  // One transaction from master m; budget bounds the wait for ack.
  task automatic txn(input logic m, input logic wr,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input int budget,
                     output int scyc,
                     output int ack_at,
                     output bit got);
    scyc = 0; ack_at = -1; got = 0;
    set_master(m, 1'b1, wr, a, d);
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (bus.s_rd | bus.s_wr) begin
        scyc++;
        chk("hold_addr", bus.s_addr, a);
        chk("hold_wdata", bus.s_wdata, d);
      end
      if (m ? bus.m1_ack : bus.m0_ack) begin
        got = 1;
        ack_at = i;
        set_master(m, 1'b0, 1'b0, '0, '0);
        break;
      end
    end
  endtask

  // Asynchronous reset mid-BUSY, checked before the next edge.
  task automatic reset_mid();
    chk("mid_busy_before", 32'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_srd", 32'(bus.s_rd), 0);
    chk("rst_async_swr", 32'(bus.s_wr), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    chk("rst_async_ack", 32'(bus.m0_ack | bus.m1_ack), 0);
    set_master(1'b0, 1'b0, 1'b0, '0, '0);
    set_master(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b1;
  endtask

  initial begin
    int  sc, at, n;
    bit  got;
    set_master(1'b0, 1'b0, 1'b0, '0, '0);
    set_master(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset held with random master inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk);
      set_master(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      set_master(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
    end
    #1;
    chk("rst_s_rd", 32'(bus.s_rd), 0);
    chk("rst_s_wr", 32'(bus.s_wr), 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_wdata", bus.s_wdata, 0);
    chk("rst_m0_ack", 32'(bus.m0_ack), 0);
    chk("rst_m1_ack", 32'(bus.m1_ack), 0);
    chk("rst_m0_rdata", bus.m0_rdata, 0);
    chk("rst_m1_rdata", bus.m1_rdata, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);

    // Continuous tie: m0 first, then strict alternation.
    @(negedge sysclk);
    reset = 1'b1;
    rd_base = 32'hDEAD_0000;
    slave_delay = 0;
    rise_cyc.delete();
    for (int i = 0; i < 2; i++) begin
      push_cmd(1'b0, 32'h0000_0100, 32'h11);
      push_cmd(1'b0, 32'h4000_0000, 32'h22);
      push_ack(1'b0, 32'hDEAD_0100, 1'b0);
      push_ack(1'b1, 32'h9EAD_0000, 1'b0);
    end
    set_master(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h11);
    set_master(1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h22);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge sysclk);
      if (bus.m0_ack | bus.m1_ack) n++;
    end
    set_master(1'b0, 1'b0, 1'b0, '0, '0);
    set_master(1'b1, 1'b0, 1'b0, '0, '0);
    chk("alt_ack_count", 32'(n), 4);
    chk("alt_rises", 32'(rise_cyc.size()), 4);
    if (rise_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk("alt_gap", 32'(rise_cyc[i] - rise_cyc[i-1]), 3);
    end
    @(negedge sysclk);

    // m0 read, immediate ready.
    rd_base = 32'h1234_5668;
    push_cmd(1'b0, 32'h0000_0010, 32'h0);
    push_ack(1'b0, 32'h1234_5678, 1'b0);
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 20, sc, at, got);
    chk("rd_got_ack", 32'(got), 1);
    chk("rd_strobe_cycles", 32'(sc), 1);
    chk("rd_ack_cycle", 32'(at), 1);
    chk("rd_m1_rdata_kept", bus.m1_rdata, 32'h9EAD_0000);
    @(negedge sysclk);

    // m1 write to peripheral space, ready after 3 waits.
    slave_delay = 3;
    push_cmd(1'b1, 32'h4000_000C, 32'hA5);
    push_ack(1'b1, 32'h9EAD_0000, 1'b0);
    txn(1'b1, 1'b1, 32'h4000_000C, 32'hA5, 20, sc, at, got);
    chk("wr_got_ack", 32'(got), 1);
    chk("wr_strobe_cycles", 32'(sc), 4);
    chk("wr_ack_cycle", 32'(at), 4);
    chk("wr_m0_rdata_kept", bus.m0_rdata, 32'h1234_5678);
    @(negedge sysclk);

    // Slave never ready.
    slave_delay = 1000000;
    push_cmd(1'b0, 32'h0000_0020, 32'h0);
`ifdef DMEM_ARB_WATCHDOG_EN
    push_ack(1'b0, 32'h0, 1'b1);
    txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 20, sc, at, got);
    chk("wd_got_ack", 32'(got), 1);
    chk("wd_strobe_cycles", 32'(sc), 4);
    chk("wd_m0_rdata", bus.m0_rdata, 32'h0);
    @(negedge sysclk);
    chk("wd_err_cleared", 32'(bus.err), 0);
`else
    txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 105, sc, at, got);
    chk("hang_no_ack", 32'(got), 0);
    chk("hang_strobe_cycles", 32'(sc), 105);
    chk("hang_err", 32'(bus.err), 0);
    reset_mid();
`endif

    // Reset in the middle of a write.
    push_cmd(1'b1, 32'h0000_0044, 32'h55);
    txn(1'b1, 1'b1, 32'h0000_0044, 32'h55, 2, sc, at, got);
    chk("mid_no_ack", 32'(got), 0);
    chk("mid_strobe_cycles", 32'(sc), 2);
    reset_mid();
    chk("post_rst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("post_rst_m1_rdata", bus.m1_rdata, 32'h0);

    // Next request after reset completes normally.
    rd_base = 32'h0;
    slave_delay = 1;
    push_cmd(1'b0, 32'h4000_0004, 32'h0);
    push_ack(1'b1, 32'h4000_0004, 1'b0);
    txn(1'b1, 1'b0, 32'h4000_0004, 32'h0, 20, sc, at, got);
    chk("post_got_ack", 32'(got), 1);
    chk("post_strobe_cycles", 32'(sc), 2);
    chk("post_ack_cycle", 32'(at), 2);

    repeat (4) @(negedge sysclk);
    chk("ack_q_drained", 32'(ack_q.size()), 0);
    chk("cmd_q_drained", 32'(cmd_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
# dmem_bus_arbiter

Two-master arbiter sharing the single data-memory/peripheral bus (DataMem plus Peripheral address space at 0x4000_0000) between the CPU load/store path (master 0) and a DMA/UART streaming engine (master 1). It grants one transaction at a time using round-robin priority. It registers the winning command onto the slave bus and holds it until the slave signals ready. It then returns read data and a one-cycle acknowledge to the owner.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum BUSY cycles before abort (only used with watchdog)

Ports:
- sysclk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low
- m0_req, m1_req  in  1  transaction request, held until ack
- m0_wr, m1_wr  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_rdata, m1_rdata  out  DW  read data, valid while ack is high
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- s_rd, s_wr  out  1  slave strobes, mutually exclusive
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_rdata  in  DW  slave read data
- s_ready  in  1  slave completion, sampled in BUSY
- busy  out  1  high in BUSY or DONE
- err  out  1  timeout pulse, coincident with ack

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY when any request is present.
  - BUSY to DONE on s_ready (or on watchdog expiry).
  - DONE to IDLE unconditionally.
- Selection in IDLE:
  - A lone requester always wins.
  - On a tie, the master not served last wins.
  - Pointer `last` resets to 1, so m0 wins the first tie.
  - `last` updates on entry to DONE.
- IDLE to BUSY edge:
  - Latches owner, wr, addr and wdata.
  - Drives s_rd = ~wr and s_wr = wr, both registered.
- BUSY:
  - Strobes, s_addr and s_wdata are held constant.
  - Master inputs are ignored.
- BUSY to DONE edge:
  - Strobes clear.
  - s_rdata is captured into the owner's rdata register.
  - Owner's ack is set for exactly one cycle.
  - On a write, rdata holds its previous value.
- Master rule: drop req, or present a new command, by the end of the ack cycle. IDLE samples req only after DONE, so a completed request is never regranted.
- The non-owner's rdata and ack are unaffected by the owner's transaction.

## Timing
- Reset values: all outputs 0, state IDLE, `last` = 1. Reset is asynchronous and takes effect mid-transaction, clearing s_rd and s_wr immediately with no ack issued.
- Latency with s_ready high in the first BUSY cycle:
  - req sampled at edge 0.
  - Strobe is high during cycle 1.
  - ack is high during cycle 2.
  - State is IDLE in cycle 3.
- Throughput is one transaction per 3 cycles plus slave wait cycles.
- Each additional cycle with s_ready low extends BUSY by one cycle.
- s_ready seen outside BUSY is ignored.

## Configuration
- DMEM_ARB_WATCHDOG_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entering BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT with s_ready still low, the FSM goes to DONE and the strobes drop.
  - Owner rdata is forced to 0 and err pulses with ack.
  - s_ready in the same cycle as expiry wins, giving a normal completion with no err.
- DMEM_ARB_WATCHDOG_EN undefined:
  - No counter.
  - BUSY waits indefinitely.
  - err is tied to 0.

## Structure
- Package dmem_arb_pkg holds:
  - state enum (IDLE/BUSY/DONE)
  - owner encoding (M0 = 0, M1 = 1)
  - default TIMEOUT
  - TIMEOUT_RDATA = 0
- One sub-module, dmem_arb_watchdog, holds the counter and expiry compare. It is instantiated only under DMEM_ARB_WATCHDOG_EN.
- Selection, latch and FSM stay in the top module.

## Test plan
- Reset: hold reset low with random inputs → all outputs 0. First tie after release → m0 granted.
- m0 read of 0x0000_0010, s_ready=1 immediately, s_rdata=0x1234_5678 → s_rd high for exactly cycle 1, m0_ack high in cycle 2, m0_rdata=0x1234_5678, m1_ack stays 0.
- m0 and m1 requesting continuously → grants alternate m0, m1, m0, m1; each ack pulse is 1 cycle with 2 idle/done cycles between strobes.
- m1 write of 0x4000_000C, wdata=0xA5, s_ready delayed 3 cycles → s_wr high for 4 cycles with stable addr/wdata, one m1_ack, m1_rdata unchanged.
- With DMEM_ARB_WATCHDOG_EN and TIMEOUT=4, s_ready never asserted → ack plus err after 4 BUSY cycles, rdata=0. Without the macro the arbiter stays BUSY for at least 100 cycles.
- Reset pulsed during BUSY → s_rd/s_wr drop asynchronously, no ack. The next request proceeds normally.
